galoi_lfsr_checker: RTL and testbench

Receive-side checker for the 16-bit Galois LFSR sequence produced by `galoi_lfsr`. Accepts one 16-bit LFSR word per valid cycle and self-synchronises by seeding its own predictor from the incoming stream. It then tracks the stream in lock, counting mismatched words. It sits at the far end of a link or loopback path carrying `out_lfsr`, and gives link-integrity status: lock plus error count.

---
 rtl/galoi_lfsr_pkg.sv | 19 +
 rtl/galoi_lfsr_checker.sv | 114 +++++++++++
 tb/tb_galoi_lfsr_checker.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/galoi_lfsr_pkg.sv
// Shared definitions for the 16-bit Galois LFSR generator and checker.
// Both ends step the sequence with lfsr_step so they cannot drift apart.
package galoi_lfsr_pkg;

   localparam int unsigned LFSR_W = 16;
   localparam logic [LFSR_W-1:0] DEF_TAPS = 16'hB400;

   typedef enum logic [1:0] {
      StHunt,
      StVerify,
      StLocked
   } state_e;

   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] state,
                                                    input logic [LFSR_W-1:0] taps);
      return (state >> 1) ^ (state[0] ? taps : '0);
   endfunction

endpackage

// File: rtl/galoi_lfsr_checker.sv
// Receive-side Galois LFSR checker: seeds its predictor from the stream, then
// free-runs in lock and counts mismatched words.
module galoi_lfsr_checker
   import galoi_lfsr_pkg::*;
#(
   parameter logic [LFSR_W-1:0] TAPS     = DEF_TAPS,
   parameter int unsigned       LOCK_CNT = 4,
   parameter int unsigned       LOSS_CNT = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [LFSR_W-1:0] in_lfsr,
   input  logic              clr_cnt,
   output logic              locked,
   output logic              err_pulse,
   output logic [LFSR_W-1:0] err_count
);

   state_e            state_q, state_d;
   logic [LFSR_W-1:0] pred_q, pred_d;
   logic [3:0]        match_q, match_d;
   logic [3:0]        miss_q, miss_d;
   logic              err_pulse_q, err_pulse_d;
   logic [LFSR_W-1:0] err_count_q, err_count_d;
   logic              count_err;
   logic              word_zero;
   logic              word_hit;

   assign word_zero = (in_lfsr == '0);
   assign word_hit  = (in_lfsr == pred_q);

   always_comb begin
      state_d     = state_q;
      pred_d      = pred_q;
      match_d     = match_q;
      miss_d      = miss_q;
      err_pulse_d = 1'b0;
      count_err   = 1'b0;

      if (in_valid) begin
         unique case (state_q)
            StHunt: begin
               // All-zero is the lock-up state and would seed a dead predictor.
               if (!word_zero) begin
                  pred_d  = lfsr_step(in_lfsr, TAPS);
                  match_d = '0;
                  state_d = StVerify;
               end
            end
            StVerify: begin
               if (word_hit) begin
                  pred_d  = lfsr_step(in_lfsr, TAPS);
                  match_d = match_q + 4'd1;
                  if (match_q + 4'd1 == 4'(LOCK_CNT)) begin
                     state_d = StLocked;
                     miss_d  = '0;
                  end
               end else if (!word_zero) begin
                  pred_d  = lfsr_step(in_lfsr, TAPS);
                  match_d = '0;
               end else begin
                  state_d = StHunt;
               end
            end
            StLocked: begin
               // Flywheel: ignore the data when advancing so errors cannot poison it.
               pred_d = lfsr_step(pred_q, TAPS);
               if (word_hit) begin
                  miss_d = '0;
               end else begin
                  err_pulse_d = 1'b1;
                  count_err   = 1'b1;
                  miss_d      = miss_q + 4'd1;
                  if (miss_q + 4'd1 == 4'(LOSS_CNT)) begin
                     state_d = StHunt;
                  end
               end
            end
            default: state_d = StHunt;
         endcase
      end

      err_count_d = err_count_q;
      if (clr_cnt) begin
         err_count_d = count_err ? LFSR_W'(1) : '0;
      end else if (count_err && err_count_q != '1) begin
         err_count_d = err_count_q + LFSR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StHunt;
         pred_q      <= '0;
         match_q     <= '0;
         miss_q      <= '0;
         err_pulse_q <= 1'b0;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         pred_q      <= pred_d;
         match_q     <= match_d;
         miss_q      <= miss_d;
         err_pulse_q <= err_pulse_d;
         err_count_q <= err_count_d;
      end
   end

   assign locked    = (state_q == StLocked);
   assign err_pulse = err_pulse_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_galoi_lfsr_checker.sv
// Scoreboard bench for galoi_lfsr_checker: directed words with hand-derived
// lock/pulse/count expectations, checked by an independent monitor.
module tb_galoi_lfsr_checker;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] in_lfsr = 16'h0000;
   logic        clr_cnt = 1'b0;
   logic        locked;
   logic        err_pulse;
   logic [15:0] err_count;

   typedef struct packed {
      logic        l;
      logic        p;
      logic [15:0] c;
   } exp_t;

   exp_t        sb[$];
   int          tests = 0;
   int          fails = 0;
   logic [15:0] w;

   galoi_lfsr_checker dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_lfsr   (in_lfsr),
      .clr_cnt   (clr_cnt),
      .locked    (locked),
      .err_pulse (err_pulse),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] nxt(input logic [15:0] s);
      logic [15:0] r;
      r = {1'b0, s[15:1]};
      if (s[0]) r = r ^ 16'hB400;
      return r;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   task automatic send(input logic [15:0] d, input logic el, input logic ep,
                       input logic [15:0] ec, input logic clr);
      @(negedge clk);
      in_valid = 1'b1;
      in_lfsr  = d;
      clr_cnt  = clr;
      sb.push_back('{l: el, p: ep, c: ec});
   endtask

   // Next word of the running sequence, optionally corrupted.
   task automatic lword(input logic ok, input logic el, input logic ep,
                        input logic [15:0] ec, input logic clr);
      w = nxt(w);
      send(ok ? w : (w ^ 16'h0010), el, ep, ec, clr);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b0;
         clr_cnt  = 1'b0;
         in_lfsr  = 16'hDEAD;
      end
   endtask

   initial begin : monitor
      logic v;
      exp_t e;
      forever begin
         @(posedge clk);
         v = in_valid & rst;
         @(negedge clk);
         if (v) begin
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL scoreboard: got empty queue expected an entry at %0t", $time);
            end else begin
               e = sb.pop_front();
               check("locked", 16'(locked), 16'(e.l));
               check("err_pulse", 16'(err_pulse), 16'(e.p));
               check("err_count", err_count, e.c);
            end
         end
      end
   end

   initial begin : stim
      #12;
      check("rst_locked", 16'(locked), 16'h0);
      check("rst_pulse", 16'(err_pulse), 16'h0);
      check("rst_count", err_count, 16'h0);
      @(negedge clk);
      rst = 1'b1;

      // Zero ignored in HUNT, then lock-up on the reference sequence
      send(16'h0000, 1'b0, 1'b0, 16'd0, 1'b0);
      send(16'h0001, 1'b0, 1'b0, 16'd0, 1'b0);
      send(16'hB400, 1'b0, 1'b0, 16'd0, 1'b0);
      send(16'h5A00, 1'b0, 1'b0, 16'd0, 1'b0);
      send(16'h2D00, 1'b0, 1'b0, 16'd0, 1'b0);
      send(16'h1680, 1'b1, 1'b0, 16'd0, 1'b0);

      // Single error, flywheel keeps the predictor on track
      send(16'h0B41, 1'b1, 1'b1, 16'd1, 1'b0);
      send(16'h05A0, 1'b1, 1'b0, 16'd1, 1'b0);
      w = 16'h05A0;

      // Gaps in in_valid stall both ends
      idle(3);
      repeat (3) lword(1'b1, 1'b1, 1'b0, 16'd1, 1'b0);

      // Lock loss on the third consecutive mismatch
      lword(1'b0, 1'b1, 1'b1, 16'd2, 1'b0);
      lword(1'b0, 1'b1, 1'b1, 16'd3, 1'b0);
      lword(1'b0, 1'b0, 1'b1, 16'd4, 1'b0);

      // Relock from a new seed, count held
      w = 16'hACE1;
      send(w, 1'b0, 1'b0, 16'd4, 1'b0);
      repeat (3) lword(1'b1, 1'b0, 1'b0, 16'd4, 1'b0);
      lword(1'b1, 1'b1, 1'b0, 16'd4, 1'b0);

      lword(1'b0, 1'b1, 1'b1, 16'd5, 1'b0);
      lword(1'b0, 1'b1, 1'b1, 16'd6, 1'b0);
      lword(1'b0, 1'b0, 1'b1, 16'd7, 1'b0);

      // VERIFY reseed after two matches needs four fresh matches
      w = 16'h1111;
      send(w, 1'b0, 1'b0, 16'd7, 1'b0);
      repeat (2) lword(1'b1, 1'b0, 1'b0, 16'd7, 1'b0);
      w = 16'h2222;
      send(w, 1'b0, 1'b0, 16'd7, 1'b0);
      repeat (3) lword(1'b1, 1'b0, 1'b0, 16'd7, 1'b0);
      lword(1'b1, 1'b1, 1'b0, 16'd7, 1'b0);

      lword(1'b0, 1'b1, 1'b1, 16'd8, 1'b0);
      lword(1'b0, 1'b1, 1'b1, 16'd9, 1'b0);
      lword(1'b0, 1'b0, 1'b1, 16'd10, 1'b0);

      // Zero in VERIFY returns to HUNT: next word is a seed, not a match
      w = 16'h1111;
      send(w, 1'b0, 1'b0, 16'd10, 1'b0);
      lword(1'b1, 1'b0, 1'b0, 16'd10, 1'b0);
      send(16'h0000, 1'b0, 1'b0, 16'd10, 1'b0);
      repeat (4) lword(1'b1, 1'b0, 1'b0, 16'd10, 1'b0);
      lword(1'b1, 1'b1, 1'b0, 16'd10, 1'b0);

      // clr_cnt coincident with a counted error
      lword(1'b0, 1'b1, 1'b1, 16'd1, 1'b1);
      lword(1'b1, 1'b1, 1'b0, 16'd1, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      clr_cnt  = 1'b1;
      @(negedge clk);
      clr_cnt = 1'b0;
      check("clr_only_count", err_count, 16'h0000);
      check("clr_only_locked", 16'(locked), 16'h1);

      // Saturation
      force dut.err_count_q = 16'hFFFF;
      @(negedge clk);
      release dut.err_count_q;
      lword(1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b0);
      lword(1'b1, 1'b1, 1'b0, 16'hFFFF, 1'b0);

      // Async reset between edges while err_pulse is high
      lword(1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b0);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      #1 rst = 1'b0;
      #1;
      check("arst_locked", 16'(locked), 16'h0);
      check("arst_pulse", 16'(err_pulse), 16'h0);
      check("arst_count", err_count, 16'h0);
      idle(2);
      @(negedge clk);
      rst = 1'b1;

      // Back in HUNT after reset: seed plus four matches
      w = 16'h0001;
      send(w, 1'b0, 1'b0, 16'd0, 1'b0);
      repeat (3) lword(1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
      lword(1'b1, 1'b1, 1'b0, 16'd0, 1'b0);
      idle(2);
      repeat (2) lword(1'b1, 1'b1, 1'b0, 16'd0, 1'b0);
      idle(3);

      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
